// File: rtl/spi_pkg.sv
// spi_pkg: shared frame width and receiver state encoding for the SPI receive path.
package spi_pkg;
  localparam int DATA_W = 12;
  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, DONE} rx_state_t;
endpackage

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: synchronous FIFO with occupancy counter; a push while full is accepted only alongside a pop.
module spi_rx_fifo #(
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_full,
  output logic              o_empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign o_full  = r_cnt == (AW+1)'(FIFO_DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_dout  = r_mem[r_rd];
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= r_wr + AW'(w_push);
      r_rd  <= r_rd + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampled SPI receiver, LSB-first frames with a leading dummy sclk fall, buffered to a valid/ready port.
module spi_slave_rx #(
  parameter int DATA_W     = spi_pkg::DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              ovf_err,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              busy
);
  import spi_pkg::*;
  localparam int BW = $clog2(DATA_W + 1);
  rx_state_t r_state, w_next;
  logic [1:0] r_sclk_sy, r_cs_sy, r_mosi_sy;
  logic r_sclk_p, r_cs_p, r_push;
  logic [BW-1:0] r_bits;
  logic [DATA_W-1:0] r_sh;
  logic w_sclk_fall, w_cs_fall, w_cs_rise, w_shift, w_last, w_ferr;
  logic w_full, w_empty, w_pop, w_drop;
  assign w_sclk_fall = r_sclk_p & ~r_sclk_sy[1];
  assign w_cs_fall   = r_cs_p & ~r_cs_sy[1];
  assign w_cs_rise   = ~r_cs_p & r_cs_sy[1];
  assign w_shift     = (r_state == SHIFT) & w_sclk_fall & ~w_cs_rise;
  assign w_last      = w_shift & (r_bits == BW'(DATA_W - 1));
  assign dout_valid  = ~w_empty;
  assign w_pop       = dout_valid & dout_ready;
  assign w_drop      = r_push & w_full & ~w_pop;
  assign busy        = r_state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // cs_rise is tested before sclk_fall so an abort in the same cycle discards the sample
  always_comb begin
    w_next = r_state;
    w_ferr = 1'b0;
    case (r_state)
      IDLE:  w_next = w_cs_fall ? SKIP : IDLE;
      SKIP:  begin
        w_ferr = w_cs_rise;
        w_next = w_cs_rise ? IDLE : (w_sclk_fall ? SHIFT : SKIP);
      end
      SHIFT: begin
        w_ferr = w_cs_rise;
        w_next = w_cs_rise ? IDLE : (w_last ? DONE : SHIFT);
      end
      DONE:  w_next = w_cs_rise ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sy <= 2'b00;
      r_cs_sy   <= 2'b11;
      r_mosi_sy <= 2'b00;
      r_sclk_p  <= 1'b0;
      r_cs_p    <= 1'b1;
      r_bits    <= '0;
      r_sh      <= '0;
      r_push    <= 1'b0;
      frame_err <= 1'b0;
      ovf_err   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      r_sclk_sy <= {r_sclk_sy[0], sclk};
      r_cs_sy   <= {r_cs_sy[0], cs};
      r_mosi_sy <= {r_mosi_sy[0], mosi};
      r_sclk_p  <= r_sclk_sy[1];
      r_cs_p    <= r_cs_sy[1];
      r_bits    <= (r_state == IDLE) ? '0 : r_bits + BW'(w_shift);
      if (w_shift) r_sh <= {r_mosi_sy[1], r_sh[DATA_W-1:1]};
      r_push    <= w_last;
      frame_err <= w_ferr;
      ovf_err   <= w_drop;
      if (w_drop && ~&drop_cnt) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end
  spi_rx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_push),
    .i_pop   (w_pop),
    .i_din   (r_sh),
    .o_dout  (dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
endmodule
